spi_slave_mlf: RTL and testbench

SPI_SLAVE_MLF -- requirements
Module: spi_slave_mlf

---
 rtl/spi_slave_mlf.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_mlf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mlf.sv
// SPI slave for CPOL/CPHA modes 0-3, oversampled by i_clk, with a one-byte TX holding register.
// Optional receive-overrun flag and i_RX_Ack handshake: define SPI_SLAVE_RX_OVERRUN_EN.
module spi_slave_mlf #(
    parameter int SPI_MODE = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    input  logic       i_RX_Ack,
    output logic       o_RX_Overrun,
`endif
    input  logic       i_SPI_clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] clk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       clk_d;
    logic       cs_d;

    logic       hold_full;
    logic [7:0] tx_hold;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;

    logic       lead_edge;
    logic       trail_edge;
    logic       cs_fall;
    logic       cs_rise;
    logic       in_frame;
    logic       sample_edge;
    logic       shift_edge;
    logic       frame_start;
    logic       byte_done;
    logic       byte_start;
    logic       tx_accept;
    logic [7:0] load_val;

    // Two-flop synchronizers, then one extra stage so edges can be seen as s2 != d.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sync  <= {2{CPOL}};
            clk_d     <= CPOL;
            cs_sync   <= 2'b11;
            cs_d      <= 1'b1;
            mosi_sync <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[0], i_SPI_clk};
            clk_d     <= clk_sync[1];
            cs_sync   <= {cs_sync[0], i_SPI_CS_n};
            cs_d      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_nxt   = state;
        lead_edge   = 1'b0;
        trail_edge  = 1'b0;
        cs_fall     = cs_d & ~cs_sync[1];
        cs_rise     = ~cs_d & cs_sync[1];

        if (clk_sync[1] != clk_d) begin
            lead_edge  = (clk_d == CPOL);
            trail_edge = (clk_sync[1] == CPOL);
        end

        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A CS_n rise wins over any SPI clock edge seen in the same cycle.
        in_frame    = (state == ACTIVE) && !cs_rise;
        sample_edge = in_frame && (CPHA ? trail_edge : lead_edge);
        shift_edge  = in_frame && (CPHA ? lead_edge : trail_edge);
        frame_start = (state == IDLE) && cs_fall;
        byte_done   = sample_edge && (bit_cnt == 3'd0);
        byte_start  = frame_start || byte_done;
        tx_accept   = i_TX_DV && !hold_full;
        load_val    = hold_full ? tx_hold : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_full  <= 1'b0;
            tx_hold    <= 8'h00;
            tx_shift   <= 8'h00;
            rx_shift   <= 7'h00;
            bit_cnt    <= 3'd7;
            o_RX_DV    <= 1'b0;
            o_RX_Byte  <= 8'h00;
            o_SPI_MISO <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;

            // A byte accepted in the same cycle as a byte start stays held for the next byte.
            if (tx_accept) begin
                tx_hold   <= i_TX_Byte;
                hold_full <= 1'b1;
            end else if (byte_start) begin
                hold_full <= 1'b0;
            end

            if (frame_start) begin
                if (CPHA) begin
                    tx_shift <= load_val;
                end else begin
                    o_SPI_MISO <= load_val[7];
                    tx_shift   <= {load_val[6:0], 1'b0};
                end
            end else if (!in_frame) begin
                o_SPI_MISO <= 1'b0;
                bit_cnt    <= 3'd7;
            end else begin
                if (shift_edge) begin
                    o_SPI_MISO <= tx_shift[7];
                    tx_shift   <= {tx_shift[6:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                    if (bit_cnt == 3'd0) begin
                        o_RX_Byte <= {rx_shift, mosi_sync[1]};
                        o_RX_DV   <= 1'b1;
                        bit_cnt   <= 3'd7;
                        tx_shift  <= load_val;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
            end
        end
    end

    assign o_TX_Ready    = !hold_full;
    assign o_SPI_MISO_En = (state == ACTIVE);

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic rx_unacked;

    // An ack arriving with a new byte acknowledges the previous one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_unacked   <= 1'b0;
            o_RX_Overrun <= 1'b0;
        end else if (byte_done) begin
            rx_unacked <= 1'b1;
            if (rx_unacked && !i_RX_Ack) begin
                o_RX_Overrun <= 1'b1;
            end
        end else if (i_RX_Ack) begin
            rx_unacked   <= 1'b0;
            o_RX_Overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Scoreboard bench for spi_slave_mlf: one instance per SPI mode, driven by a bit-level SPI master.
// Exercises SPI_SLAVE_RX_OVERRUN_EN as well when that macro is defined.
module tb_spi_slave_mlf;

    localparam int H = 6;  // SPI half-period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] spi_clk, cs_n, mosi, tx_dv, tx_ready, rx_dv, miso, miso_en;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic [3:0] rx_ack, rx_ovr;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_rx [4][$];
    int         model_hold [4];   // -1 means holding register empty
    logic [7:0] last_rx [4];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_mlf #(.SPI_MODE(g)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_TX_Byte    (tx_byte[g]),
            .i_TX_DV      (tx_dv[g]),
            .o_TX_Ready   (tx_ready[g]),
            .o_RX_DV      (rx_dv[g]),
            .o_RX_Byte    (rx_byte[g]),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            .i_RX_Ack     (rx_ack[g]),
            .o_RX_Overrun (rx_ovr[g]),
`endif
            .i_SPI_clk    (spi_clk[g]),
            .i_SPI_CS_n   (cs_n[g]),
            .i_SPI_MOSI   (mosi[g]),
            .o_SPI_MISO   (miso[g]),
            .o_SPI_MISO_En(miso_en[g])
        );

        always @(negedge clk) begin : mon
            logic [7:0] e;
            if (!rst && rx_dv[g]) begin
                if (exp_rx[g].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_dv_unexpected[%0d]: got pulse with %02h, required no pulse", g, rx_byte[g]);
                end else begin
                    e = exp_rx[g].pop_front();
                    check($sformatf("rx_byte[%0d]", g), rx_byte[g], e);
                end
            end
        end
    end

    function automatic logic [7:0] take_hold(input int g);
        logic [7:0] v;
        v = (model_hold[g] < 0) ? 8'h00 : 8'(model_hold[g]);
        model_hold[g] = -1;
        return v;
    endfunction

    task automatic load_tx(input int g, input logic [7:0] v);
        @(negedge clk);
        check($sformatf("tx_ready_before[%0d]", g), {7'd0, tx_ready[g]},
              (model_hold[g] < 0) ? 8'd1 : 8'd0);
        tx_byte[g] = v;
        tx_dv[g]   = 1'b1;
        @(negedge clk);
        tx_dv[g] = 1'b0;
        if (model_hold[g] < 0) model_hold[g] = int'(v);
        check($sformatf("tx_ready_after[%0d]", g), {7'd0, tx_ready[g]}, 8'd0);
    endtask

    // SPI master: sends nbits bits of mo[] MSB first, captures MISO, then raises CS_n.
    task automatic spi_frame(input int g, input logic [7:0] mo [4], input int nbits);
        logic       cpol, cpha;
        logic [7:0] cap, exp_miso;
        int         k;
        cpol = (g >= 2);
        cpha = (g % 2 == 1);
        cap  = 8'h00;
        for (int i = 0; i < nbits / 8; i++) exp_rx[g].push_back(mo[i]);
        exp_miso = take_hold(g);
        cs_n[g] = 1'b0;
        mosi[g] = cpha ? 1'b0 : mo[0][7];
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            k = 7 - i % 8;
            if (i == 0) check($sformatf("miso_en_active[%0d]", g), {7'd0, miso_en[g]}, 8'd1);
            if (!cpha) begin
                cap = {cap[6:0], miso[g]};
                spi_clk[g] = ~cpol;
                repeat (H) @(negedge clk);
                spi_clk[g] = cpol;
                if (i + 1 < nbits) mosi[g] = mo[(i + 1) / 8][7 - (i + 1) % 8];
                repeat (H) @(negedge clk);
            end else begin
                spi_clk[g] = ~cpol;
                mosi[g]    = mo[i / 8][k];
                repeat (H) @(negedge clk);
                cap = {cap[6:0], miso[g]};
                spi_clk[g] = cpol;
                repeat (H) @(negedge clk);
            end
            if (k == 0) begin
                check($sformatf("miso_byte[%0d]", g), cap, exp_miso);
                exp_miso = take_hold(g);
            end
        end
        cs_n[g] = 1'b1;
        mosi[g] = 1'b0;
        repeat (2 * H) @(negedge clk);
        check($sformatf("miso_en_idle[%0d]", g), {7'd0, miso_en[g]}, 8'd0);
        check($sformatf("miso_idle[%0d]", g), {7'd0, miso[g]}, 8'd0);
        if (nbits >= 8) last_rx[g] = mo[nbits / 8 - 1];
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        check($sformatf("%s_tx_ready[%0d]", tag, g), {7'd0, tx_ready[g]}, 8'd1);
        check($sformatf("%s_rx_dv[%0d]", tag, g), {7'd0, rx_dv[g]}, 8'd0);
        check($sformatf("%s_rx_byte[%0d]", tag, g), rx_byte[g], 8'h00);
        check($sformatf("%s_miso[%0d]", tag, g), {7'd0, miso[g]}, 8'd0);
        check($sformatf("%s_miso_en[%0d]", tag, g), {7'd0, miso_en[g]}, 8'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst     = 1'b1;
        spi_clk = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 4'h0;
        tx_dv   = 4'h0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        rx_ack  = 4'h0;
`endif
        for (int g = 0; g < 4; g++) begin
            tx_byte[g]    = 8'h00;
            model_hold[g] = -1;
            last_rx[g]    = 8'h00;
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < 4; g++) check_reset_outputs(g, "por");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 3: preloaded A5 returned while 3C is received.
        load_tx(3, 8'hA5);
        spi_frame(3, '{8'h3C, 8'h00, 8'h00, 8'h00}, 8);

        // Nothing loaded: MISO returns zeros.
        spi_frame(3, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8);

        // Mode 0: back-to-back bytes, second TX byte loaded during the first byte.
        load_tx(0, 8'h5A);
        fork
            spi_frame(0, '{8'h01, 8'h80, 8'h00, 8'h00}, 16);
            begin
                repeat (30) @(negedge clk);
                load_tx(0, 8'hC3);
            end
        join

        // Aborted byte leaves o_RX_Byte alone; the next full byte is received.
        spi_frame(3, '{8'hE7, 8'h00, 8'h00, 8'h00}, 5);
        check("rx_byte_after_abort[3]", rx_byte[3], last_rx[3]);
        spi_frame(3, '{8'h96, 8'h00, 8'h00, 8'h00}, 8);

        // Randomized frames in every mode.
        for (int g = 0; g < 4; g++) begin
            for (int r = 0; r < 6; r++) begin
                logic [7:0] mo [4];
                int nb;
                if ($urandom_range(0, 1) == 1) load_tx(g, 8'($urandom));
                if ($urandom_range(0, 3) == 0) load_tx(g, 8'($urandom));
                nb = $urandom_range(1, 3);
                for (int i = 0; i < 4; i++) mo[i] = 8'($urandom);
                spi_frame(g, mo, nb * 8);
            end
        end

        // Reset in the middle of a mode 3 byte.
        load_tx(2, 8'h77);
        fork
            spi_frame(3, '{8'h81, 8'h00, 8'h00, 8'h00}, 6);
            begin
                repeat (5 * H + 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs(3, "midrst");
            end
        join
        for (int g = 0; g < 4; g++) begin
            model_hold[g] = -1;
            last_rx[g]    = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("tx_ready_after_rst[2]", {7'd0, tx_ready[2]}, 8'd1);
        spi_frame(3, '{8'h42, 8'h00, 8'h00, 8'h00}, 8);

`ifdef SPI_SLAVE_RX_OVERRUN_EN
        @(negedge clk) rx_ack[3] = 1'b1;
        @(negedge clk) rx_ack[3] = 1'b0;
        @(negedge clk);
        check("overrun_cleared_pre[3]", {7'd0, rx_ovr[3]}, 8'd0);
        spi_frame(3, '{8'h11, 8'h22, 8'h00, 8'h00}, 16);
        check("overrun_set[3]", {7'd0, rx_ovr[3]}, 8'd1);
        @(negedge clk) rx_ack[3] = 1'b1;
        @(negedge clk) rx_ack[3] = 1'b0;
        @(negedge clk);
        check("overrun_cleared[3]", {7'd0, rx_ovr[3]}, 8'd0);
`endif

        repeat (10) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rx_pending[%0d]", g), 8'(exp_rx[g].size()), 8'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
